// File: rtl/spi_master_param.sv
// spi_master_param
//   Parametrised, fully synchronous SPI master supporting all four SPI modes.
//   SCLK is a registered output generated from mainclk. No derived or gated
//   clocks are used inside the block.
//
//   Optional macro SPI_LSB_FIRST_EN adds the lsb_first input, which is
//   latched at accept. When it is 1, words are shifted LSB first.
//
// Ports
//   mainclk    : system clock; all logic is on its rising edge
//   reset      : synchronous, active-high reset
//   start      : transfer request, sampled only in IDLE
//   spi_mode   : {CPOL, CPHA}, latched at accept
//   slave_sel  : target slave index, latched at accept
//   tx_data    : word to send, latched at accept
//   lsb_first  : (SPI_LSB_FIRST_EN only) bit order select, latched at accept
//   rx_data    : last received word, updated in the done cycle
//   busy       : transfer in progress
//   done       : one-cycle completion pulse
//   sclk       : SPI clock
//   mosi       : serial data out
//   miso       : serial data in, sampled directly on mainclk
//   cs_n       : active-low chip selects
module spi_master_param #(
   parameter int unsigned  DATA_W     = 8,
   parameter int unsigned  CLK_DIV    = 4,
   parameter int unsigned  NUM_SLAVES = 2,
   localparam int unsigned SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
   input  logic                  mainclk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            spi_mode,
   input  logic [SEL_W-1:0]      slave_sel,
   input  logic [DATA_W-1:0]     tx_data,
`ifdef SPI_LSB_FIRST_EN
   input  logic                  lsb_first,
`endif
   output logic [DATA_W-1:0]     rx_data,
   output logic                  busy,
   output logic                  done,
   output logic                  sclk,
   output logic                  mosi,
   input  logic                  miso,
   output logic [NUM_SLAVES-1:0] cs_n
);

   localparam int unsigned CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned EDGE_W = $clog2(2 * DATA_W + 1);

   typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

   state_t                  state_q, state_d;
   logic [1:0]              mode_q, mode_d;
   logic                    lsb_q, lsb_d, lsb_in;
   logic [DATA_W-1:0]       tx_q, tx_d;
   logic [DATA_W-1:0]       rxsh_q, rxsh_d;
   logic [DATA_W-1:0]       rx_q, rx_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [EDGE_W-1:0]       edge_q, edge_d;
   logic                    sclk_q, sclk_d;
   logic                    mosi_q, mosi_d;
   logic [NUM_SLAVES-1:0]   cs_q, cs_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    half_end, lead, last_edge;

`ifdef SPI_LSB_FIRST_EN
   assign lsb_in = lsb_first;
`else
   assign lsb_in = 1'b0;
`endif

   // Bit at the head of the outgoing word for the selected bit order
   function automatic logic head_bit(input logic [DATA_W-1:0] v, input logic lsb);
      return lsb ? v[0] : v[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
      return lsb ? (v >> 1) : (v << 1);
   endfunction

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      lsb_d     = lsb_q;
      tx_d      = tx_q;
      rxsh_d    = rxsh_q;
      rx_d      = rx_q;
      cnt_d     = cnt_q;
      edge_d    = edge_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      cs_d      = cs_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      half_end  = (cnt_q == CNT_W'(CLK_DIV - 1));
      lead      = 1'b0;
      last_edge = 1'b0;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            sclk_d = mode_q[1];
            if (start) begin
               state_d = SETUP;
               busy_d  = 1'b1;
               mode_d  = spi_mode;
               lsb_d   = lsb_in;
               sclk_d  = spi_mode[1];
               cnt_d   = '0;
               edge_d  = '0;
               rxsh_d  = '0;
               cs_d    = '1;
               for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
                  if (slave_sel == SEL_W'(i)) cs_d[i] = 1'b0;
               end
               // CPHA=0 presents the first bit before the first edge, so it
               // is consumed here; CPHA=1 keeps the whole word for the edges.
               if (spi_mode[0]) begin
                  tx_d   = tx_data;
                  mosi_d = 1'b0;
               end else begin
                  tx_d   = shift_out(tx_data, lsb_in);
                  mosi_d = head_bit(tx_data, lsb_in);
               end
            end
         end

         // SETUP is the first half-period; its expiry produces edge 1.
         // Every later half-period in XFER ends with the next edge, except
         // the final one, which forms the trailing gap before HOLD.
         SETUP, XFER: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (half_end) begin
               cnt_d = '0;
               if (edge_q == EDGE_W'(2 * DATA_W)) begin
                  state_d = HOLD;
               end else begin
                  state_d   = XFER;
                  edge_d    = edge_q + EDGE_W'(1);
                  sclk_d    = ~sclk_q;
                  lead      = ~edge_q[0];
                  last_edge = (edge_q == EDGE_W'(2 * DATA_W - 1));
                  // Sample on leading when CPHA=0, on trailing when CPHA=1
                  if (lead != mode_q[0]) begin
                     rxsh_d = lsb_q ? {miso, rxsh_q[DATA_W-1:1]}
                                    : {rxsh_q[DATA_W-2:0], miso};
                  end
                  if ((lead == mode_q[0]) && !last_edge) begin
                     mosi_d = head_bit(tx_q, lsb_q);
                     tx_d   = shift_out(tx_q, lsb_q);
                  end
               end
            end
         end

         HOLD: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (half_end) begin
               state_d = DONE;
               cnt_d   = '0;
               edge_d  = '0;
               done_d  = 1'b1;
               rx_d    = rxsh_q;
               cs_d    = '1;
            end
         end

         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge mainclk) begin
      if (reset) begin
         state_q <= IDLE;
         mode_q  <= '0;
         lsb_q   <= 1'b0;
         tx_q    <= '0;
         rxsh_q  <= '0;
         rx_q    <= '0;
         cnt_q   <= '0;
         edge_q  <= '0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         cs_q    <= '1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         lsb_q   <= lsb_d;
         tx_q    <= tx_d;
         rxsh_q  <= rxsh_d;
         rx_q    <= rx_d;
         cnt_q   <= cnt_d;
         edge_q  <= edge_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         cs_q    <= cs_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign rx_data = rx_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign sclk    = sclk_q;
   assign mosi    = mosi_q;
   assign cs_n    = cs_q;

endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param
//   Scoreboarded bench for spi_master_param. A negedge monitor plays the SPI
//   slave, collects mosi bits on leading edges and checks each done pulse
//   against expected words queued when the transfer was started.
module tb_spi_master_param;

   localparam int unsigned DW  = 8;
   localparam int unsigned CD  = 4;
   localparam int unsigned NS  = 2;
   localparam int          LAT = 1 + CD * (2 * DW + 2);
   localparam int          LAT3 = 1 + 2 * (2 * DW + 2);

   logic          mainclk = 1'b0;
   logic          reset, start, miso;
   logic [1:0]    spi_mode;
   logic [0:0]    slave_sel;
   logic [DW-1:0] tx_data;
   logic [DW-1:0] rx_data;
   logic          busy, done, sclk, mosi;
   logic [NS-1:0] cs_n;

   logic          start3, miso3;
   logic [1:0]    sel3;
   logic [DW-1:0] rx3;
   logic          busy3, done3, sclk3, mosi3;
   logic [2:0]    cs_n3;
`ifdef SPI_LSB_FIRST_EN
   logic          lsb_first;
`endif

   int errors = 0;
   int checks = 0;

   always #5 mainclk = ~mainclk;

   spi_master_param #(.DATA_W(DW), .CLK_DIV(CD), .NUM_SLAVES(NS)) u_dut (
      .mainclk(mainclk), .reset(reset), .start(start), .spi_mode(spi_mode),
      .slave_sel(slave_sel), .tx_data(tx_data),
`ifdef SPI_LSB_FIRST_EN
      .lsb_first(lsb_first),
`endif
      .rx_data(rx_data), .busy(busy), .done(done), .sclk(sclk), .mosi(mosi),
      .miso(miso), .cs_n(cs_n)
   );

   spi_master_param #(.DATA_W(DW), .CLK_DIV(2), .NUM_SLAVES(3)) u_dut3 (
      .mainclk(mainclk), .reset(reset), .start(start3), .spi_mode(spi_mode),
      .slave_sel(sel3), .tx_data(tx_data),
`ifdef SPI_LSB_FIRST_EN
      .lsb_first(lsb_first),
`endif
      .rx_data(rx3), .busy(busy3), .done(done3), .sclk(sclk3), .mosi(mosi3),
      .miso(miso3), .cs_n(cs_n3)
   );

   // Scoreboard and slave model state
   logic [DW-1:0] exp_rx_q[$];
   logic [DW-1:0] exp_tx_q[$];
   logic [DW-1:0] slv_q[$];
   logic [1:0]    cur_mode;
   logic          cur_lsb;
   logic [DW-1:0] slv_word, mosi_sh, e;
   int            slv_idx, edges, cyc, done_cnt;
   logic          active, busy_p, sclk_p;

   function automatic logic slv_bit(input logic [DW-1:0] w, input int i, input logic lsb);
      return lsb ? w[i] : w[DW-1-i];
   endfunction

   always @(negedge mainclk) begin
      if (reset) begin
         active = 1'b0;
         busy_p = 1'b0;
         sclk_p = sclk;
      end else begin
         if (busy === 1'b1 && !busy_p) begin
            active  = 1'b1;
            cyc     = 1;
            edges   = 0;
            mosi_sh = '0;
            slv_word = (slv_q.size() > 0) ? slv_q.pop_front() : '0;
            slv_idx = 0;
            if (!cur_mode[0]) begin
               miso = slv_bit(slv_word, 0, cur_lsb);
               slv_idx = 1;
            end
         end else if (active) begin
            cyc++;
            if (sclk !== sclk_p) begin
               edges++;
               if (sclk !== cur_mode[1]) begin
                  mosi_sh = cur_lsb ? {mosi, mosi_sh[DW-1:1]} : {mosi_sh[DW-2:0], mosi};
                  if (cur_mode[0] && slv_idx < DW) begin
                     miso = slv_bit(slv_word, slv_idx, cur_lsb);
                     slv_idx++;
                  end
               end else if (!cur_mode[0] && slv_idx < DW) begin
                  miso = slv_bit(slv_word, slv_idx, cur_lsb);
                  slv_idx++;
               end
            end
         end
         if (done === 1'b1) begin
            done_cnt++;
            checks++;
            if (!active || cyc != LAT) begin
               errors++;
               $display("FAIL done_latency: got cycle %0d (active=%0b) expected %0d", cyc, active, LAT);
            end
            checks++;
            if (exp_rx_q.size() == 0) begin
               errors++;
               $display("FAIL rx_scoreboard: got rx_data=%h with no expected word queued", rx_data);
            end else begin
               e = exp_rx_q.pop_front();
               if (rx_data !== e) begin
                  errors++;
                  $display("FAIL rx_data: got %h expected %h", rx_data, e);
               end
            end
            checks++;
            if (exp_tx_q.size() == 0) begin
               errors++;
               $display("FAIL mosi_scoreboard: got mosi word %h with no expected word queued", mosi_sh);
            end else begin
               e = exp_tx_q.pop_front();
               if (mosi_sh !== e) begin
                  errors++;
                  $display("FAIL mosi_sequence: got %h expected %h", mosi_sh, e);
               end
            end
            checks++;
            if (edges != 2 * DW) begin
               errors++;
               $display("FAIL sclk_edges: got %0d expected %0d", edges, 2 * DW);
            end
            checks++;
            if (cs_n !== 2'b11) begin
               errors++;
               $display("FAIL cs_n_at_done: got %b expected 11", cs_n);
            end
            active = 1'b0;
         end
         busy_p = busy;
         sclk_p = sclk;
      end
   end

   // Drives one request at a negedge and returns at the T+1 negedge
   task automatic start_xfer(input logic [1:0] m, input logic [0:0] sel,
                             input logic [DW-1:0] tx, input logic [DW-1:0] sw,
                             input logic lsb);
      cur_mode  = m;
      cur_lsb   = lsb;
      spi_mode  = m;
      slave_sel = sel;
      tx_data   = tx;
`ifdef SPI_LSB_FIRST_EN
      lsb_first = lsb;
`endif
      exp_rx_q.push_back(sw);
      exp_tx_q.push_back(tx);
      slv_q.push_back(sw);
      start = 1'b1;
      @(negedge mainclk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, output int k);
      k = 1;
      while (done !== 1'b1 && k < 400) begin
         @(negedge mainclk);
         k++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s_timeout: got no done after %0d cycles expected done at %0d", name, k, LAT);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge mainclk);
      checks++;
      if (cs_n !== 2'b11) begin errors++; $display("FAIL reset_cs_n: got %b expected 11", cs_n); end
      checks++;
      if (sclk !== 1'b0 || mosi !== 1'b0) begin
         errors++; $display("FAIL reset_sclk_mosi: got %b%b expected 00", sclk, mosi);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done);
      end
      checks++;
      if (rx_data !== '0) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
      reset = 1'b0;
      @(negedge mainclk);
   endtask

   task automatic test_mode(input logic [1:0] m);
      int k;
      start_xfer(m, 1'b0, 8'hA5, 8'h3C, 1'b0);
      checks++;
      if (cs_n !== 2'b10 || busy !== 1'b1) begin
         errors++; $display("FAIL mode%0d_accept: got cs_n=%b busy=%b expected cs_n=10 busy=1", m, cs_n, busy);
      end
      checks++;
      if (sclk !== m[1]) begin errors++; $display("FAIL mode%0d_sclk_setup: got %b expected %b", m, sclk, m[1]); end
      if (!m[0]) begin
         checks++;
         if (mosi !== 1'b1) begin errors++; $display("FAIL mode%0d_mosi_first: got %b expected 1", m, mosi); end
      end
      wait_done($sformatf("mode%0d", m), k);
      checks++;
      if (k != LAT) begin errors++; $display("FAIL mode%0d_done_cycle: got %0d expected %0d", m, k, LAT); end
      @(negedge mainclk);
      checks++;
      if (busy !== 1'b0 || sclk !== m[1]) begin
         errors++; $display("FAIL mode%0d_idle: got busy=%b sclk=%b expected busy=0 sclk=%b", m, busy, sclk, m[1]);
      end
   endtask

   task automatic test_back_to_back;
      int d1, d2, gap, k, dc0;
      cur_mode = 2'b00; cur_lsb = 1'b0; spi_mode = 2'b00; slave_sel = 1'b0; tx_data = 8'h12;
      exp_rx_q.push_back(8'h81); exp_tx_q.push_back(8'h12); slv_q.push_back(8'h81);
      exp_rx_q.push_back(8'h7E); exp_tx_q.push_back(8'h34); slv_q.push_back(8'h7E);
      dc0 = done_cnt; d1 = 0; d2 = 0; gap = 0; k = 0;
      start = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge mainclk);
         k++;
         if (k == 1) tx_data = 8'h34;
         if (done === 1'b1) begin
            if (d1 == 0) d1 = k;
            else if (d2 == 0) begin d2 = k; start = 1'b0; end
         end
         if (d1 != 0 && d2 == 0 && k > d1 && cs_n === 2'b11) gap++;
      end
      start = 1'b0;
      checks++;
      if (d1 != LAT) begin errors++; $display("FAIL b2b_first_done: got %0d expected %0d", d1, LAT); end
      checks++;
      if (d2 - d1 != LAT + 1) begin errors++; $display("FAIL b2b_second_done: got gap %0d expected %0d", d2 - d1, LAT + 1); end
      checks++;
      if (gap < 1) begin errors++; $display("FAIL b2b_cs_gap: got %0d expected >=1", gap); end
      checks++;
      if (done_cnt - dc0 != 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - dc0); end
   endtask

   task automatic test_slave_sel;
      int k, got, cs_bad;
      start_xfer(2'b00, 1'b1, 8'hC3, 8'h5A, 1'b0);
      checks++;
      if (cs_n !== 2'b01) begin errors++; $display("FAIL sel1_cs_n: got %b expected 01", cs_n); end
      wait_done("sel1", k);
      @(negedge mainclk);
      miso3 = 1'b1; sel3 = 2'd3; spi_mode = 2'b00; tx_data = 8'h55; start3 = 1'b1;
      @(negedge mainclk);
      start3 = 1'b0;
      k = 1; got = 0; cs_bad = 0;
      checks++;
      if (busy3 !== 1'b1) begin errors++; $display("FAIL sel3_busy: got %b expected 1", busy3); end
      while (k < 200) begin
         if (cs_n3 !== 3'b111) cs_bad++;
         if (done3 === 1'b1) begin got = k; break; end
         @(negedge mainclk);
         k++;
      end
      checks++;
      if (got != LAT3) begin errors++; $display("FAIL sel3_done_cycle: got %0d expected %0d", got, LAT3); end
      checks++;
      if (cs_bad != 0) begin errors++; $display("FAIL sel3_cs_n: got %0d asserted cycles expected 0", cs_bad); end
      checks++;
      if (rx3 !== 8'hFF) begin errors++; $display("FAIL sel3_rx_data: got %h expected ff", rx3); end
      @(negedge mainclk);
   endtask

   task automatic test_reset_mid;
      int k, n, dc0;
      logic sp;
      start_xfer(2'b00, 1'b0, 8'hA5, 8'h3C, 1'b0);
      n = 0; k = 0; sp = sclk;
      while (n < 5 && k < 200) begin
         @(negedge mainclk);
         k++;
         if (sclk !== sp) n++;
         sp = sclk;
      end
      checks++;
      if (n != 5) begin errors++; $display("FAIL rstmid_edges: got %0d expected 5", n); end
      dc0 = done_cnt;
      reset = 1'b1;
      @(negedge mainclk);
      checks++;
      if (cs_n !== 2'b11 || sclk !== 1'b0) begin
         errors++; $display("FAIL rstmid_pins: got cs_n=%b sclk=%b expected cs_n=11 sclk=0", cs_n, sclk);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL rstmid_busy_done: got %b%b expected 00", busy, done);
      end
      checks++;
      if (rx_data !== '0) begin errors++; $display("FAIL rstmid_rx_data: got %h expected 00", rx_data); end
      @(negedge mainclk);
      reset = 1'b0;
      exp_rx_q.delete(); exp_tx_q.delete(); slv_q.delete();
      checks++;
      if (done_cnt != dc0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_cnt - dc0); end
      start_xfer(2'b00, 1'b0, 8'h5A, 8'hC3, 1'b0);
      wait_done("rstmid_restart", k);
      checks++;
      if (k != LAT) begin errors++; $display("FAIL rstmid_restart_cycle: got %0d expected %0d", k, LAT); end
      @(negedge mainclk);
   endtask

`ifdef SPI_LSB_FIRST_EN
   task automatic test_lsb_first;
      int k;
      start_xfer(2'b00, 1'b0, 8'h01, 8'h80, 1'b1);
      checks++;
      if (mosi !== 1'b1) begin errors++; $display("FAIL lsb_mosi_first: got %b expected 1", mosi); end
      wait_done("lsb", k);
      @(negedge mainclk);
      lsb_first = 1'b0;
   endtask
`endif

   initial begin
      reset = 1'b1; start = 1'b0; miso = 1'b0; spi_mode = 2'b00; slave_sel = 1'b0;
      tx_data = '0; start3 = 1'b0; miso3 = 1'b0; sel3 = '0;
      cur_mode = 2'b00; cur_lsb = 1'b0; done_cnt = 0; active = 1'b0; busy_p = 1'b0; sclk_p = 1'b0;
`ifdef SPI_LSB_FIRST_EN
      lsb_first = 1'b0;
`endif
      test_reset();
      for (int m = 0; m < 4; m++) test_mode(2'(m));
      test_back_to_back();
      test_slave_sel();
      test_reset_mid();
`ifdef SPI_LSB_FIRST_EN
      test_lsb_first();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parametrised, fully synchronous SPI master that replaces the fixed 8-bit divided-clock SPI block used by the Doppler control path.
- Supports all four SPI modes, configurable word width, clock divider and slave-select count.
- Provides a start/busy/done handshake.
- SCLK is a registered output generated from mainclk; no derived or gated clocks inside the block.
- Sits between the host-side register logic and external ADC/DAC/PLL configuration devices.

Parameters:
- DATA_W, 8: bits per transfer, legal range 2..32.
- CLK_DIV, 4: mainclk cycles per SCLK half-period, minimum 1.
- NUM_SLAVES, 2: number of cs_n lines, minimum 1. Derived SEL_W = max(1, clog2(NUM_SLAVES)).

Ports:
- mainclk, in, 1: system clock. All logic is on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: transfer request. Sampled only in IDLE.
- spi_mode, in, 2: bit1 = CPOL, bit0 = CPHA. Latched when start is accepted.
- slave_sel, in, SEL_W: target slave index. Latched when start is accepted.
- tx_data, in, DATA_W: word to send, MSB first. Latched when start is accepted.
- rx_data, out, DATA_W: last received word. Valid from the done cycle, held until the next done.
- busy, out, 1: transfer in progress.
- done, out, 1: one-cycle completion pulse.
- sclk, out, 1: SPI clock.
- mosi, out, 1: serial data out.
- miso, in, 1: serial data in.
- cs_n, out, NUM_SLAVES: active-low chip selects.

Behaviour:
- Reset values:
  - state = IDLE, latched mode = 0.
  - sclk = 0, mosi = 0, cs_n = all ones.
  - busy = 0, done = 0, rx_data = 0, all counters 0.
- States: IDLE -> SETUP -> XFER -> HOLD -> DONE -> IDLE.
- IDLE:
  - start=1 in cycle T accepts the request and latches spi_mode, slave_sel and tx_data.
  - At T+1: state = SETUP, busy = 1, selected cs_n bit = 0, sclk = latched CPOL.
  - If CPHA=0, mosi = tx MSB at T+1.
- SETUP: lasts CLK_DIV cycles, i.e. one half-period before the first SCLK edge.
- XFER:
  - 2*DATA_W half-periods of CLK_DIV cycles each; sclk toggles at the end of every half-period.
  - Edges alternate leading, trailing. Leading = away from CPOL.
  - CPHA=0: sample miso on leading edges; drive the next mosi bit on trailing edges, except after the last bit.
  - CPHA=1: drive mosi on leading edges (MSB on the first); sample miso on trailing edges.
  - Sampled bits shift into an internal shift register, MSB first.
- HOLD:
  - CLK_DIV cycles with sclk = CPOL and cs_n still asserted.
  - Ends with the last SCLK edge-to-CS deassert gap.
- DONE:
  - Exactly one cycle: done = 1, rx_data loaded from the shift register, cs_n = all ones, busy = 1.
  - Next cycle: IDLE, busy = 0.
- Timing: done is asserted at cycle T+1+CLK_DIV*(2*DATA_W+2). Back-to-back start is accepted in the cycle after DONE.
- start while busy is ignored. No queueing, no error flag.
- Changes to spi_mode, slave_sel or tx_data during a transfer have no effect.
- slave_sel >= NUM_SLAVES: transfer runs with normal timing and rx_data update, but no cs_n bit is asserted.
- miso is sampled directly on mainclk with no synchroniser. Board timing guarantees setup at CLK_DIV >= 2; at CLK_DIV = 1 this is the integrator's responsibility.
- Reset mid-transfer:
  - Abort next cycle to reset values, with cs_n released immediately.
  - No done pulse; rx_data is cleared to 0.
- Idle sclk tracks the latched CPOL. A mode change only takes effect at the next accept.

Optional Feature:
SPI_LSB_FIRST_EN
- Defined: adds input port lsb_first (1 bit), latched at accept. When 1, tx_data is sent LSB first and received bits are assembled LSB first, so rx_data bit 0 is the first bit sampled. Timing is unchanged.
- Undefined: no lsb_first port; transfers are always MSB first.

Test Plan:
1. Mode 0, DATA_W=8, CLK_DIV=4, tx_data=0xA5, slave model returns 0x3C, start at T.
   -> cs_n[0]=0 at T+1.
   -> mosi on leading edges = 1,0,1,0,0,1,0,1.
   -> rx_data=0x3C, done=1 exactly at T+73, cs_n=2'b11 at T+73.
2. Repeat scenario 1 in modes 1, 2 and 3.
   -> Idle sclk = CPOL.
   -> Sample and drive edges swap per CPHA.
   -> rx_data=0x3C and mosi sequence identical in all four modes.
3. start held high continuously, two words 0x12 then 0x34.
   -> Second accept in the cycle after the first done.
   -> Pulses during busy ignored; exactly 2 done pulses.
   -> cs_n high for at least 1 cycle between words.
4. slave_sel=1 with NUM_SLAVES=2, then slave_sel=3 with SEL_W=2 (NUM_SLAVES=3).
   -> Only cs_n[1] asserts in the first case.
   -> In the out-of-range case no cs_n asserts, but done still pulses.
5. Reset asserted at the 5th SCLK edge.
   -> Next cycle: cs_n all ones, sclk=0, busy=0, rx_data=0, no done.
   -> A new start afterwards completes normally.
6. With SPI_LSB_FIRST_EN, lsb_first=1, tx_data=0x01, slave returns 0x80 LSB first.
   -> mosi first bit = 1.
   -> rx_data=0x80.
